// File: rtl/pwl_pkg.sv
// Shared definitions for the piecewise-linear evaluator: table-select codes,
// default widths and the saturating reducer used by the output stage.
package pwl_pkg;

    localparam int PWL_DATA_W = 32;
    localparam int PWL_FRAC_W = 16;
    localparam int SAT_MAXW   = 128;

    typedef enum logic [1:0] {
        CFG_BP  = 2'd0,
        CFG_M   = 2'd1,
        CFG_C   = 2'd2,
        CFG_RSV = 2'd3
    } cfg_sel_e;

    // Clamp a signed value into the range of a signed 'width'-bit number.
    // The result stays sign-extended in the wide container.
    function automatic logic signed [SAT_MAXW-1:0] sat_trunc(
        input logic signed [SAT_MAXW-1:0] value,
        input int                         width
    );
        logic signed [SAT_MAXW-1:0] v_hi;
        logic signed [SAT_MAXW-1:0] v_lo;
        v_hi = (SAT_MAXW'(1) <<< (width - 1)) - SAT_MAXW'(1);
        v_lo = ~v_hi;
        if (value > v_hi) begin
            return v_hi;
        end else if (value < v_lo) begin
            return v_lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/pwl_seg_index.sv
// Segment classifier: thermometer compare of x against every breakpoint,
// then a popcount of the breakpoints that x reaches or exceeds.
module pwl_seg_index #(
    parameter int SEG    = 5,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(SEG)
) (
    input  logic signed [DATA_W-1:0]     i_x,
    input  logic [SEG-2:0][DATA_W-1:0]   i_bp,
    output logic [IDX_W-1:0]             o_seg
);

    logic [SEG-2:0] w_therm;

    genvar gi;
    generate
        for (gi = 0; gi < SEG - 1; gi++) begin : g_cmp
            assign w_therm[gi] = (i_x >= $signed(i_bp[gi]));
        end
    endgenerate

    // A count rather than a priority encode keeps non-ascending tables well defined.
    always_comb begin
        o_seg = '0;
        for (int k = 0; k < SEG - 1; k++) begin
            o_seg = o_seg + IDX_W'(w_therm[k]);
        end
    end

endmodule

// File: rtl/pwl_eval_pipe.sv
// Three-stage y = m[seg]*x + c[seg] evaluator with a writable coefficient table.
// Define PWL_SAT_EN for saturating arithmetic; otherwise the result wraps.
module pwl_eval_pipe
    import pwl_pkg::*;
#(
    parameter int DATA_W = PWL_DATA_W,
    parameter int FRAC_W = PWL_FRAC_W,
    parameter int SEG    = 5,
    parameter int IDX_W  = $clog2(SEG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_seg,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [3:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata
);

    logic [DATA_W-1:0]          r_bp [SEG-1];
    logic [DATA_W-1:0]          r_m  [SEG];
    logic [DATA_W-1:0]          r_c  [SEG];
    logic [SEG-2:0][DATA_W-1:0] w_bp;
    cfg_sel_e                   w_sel;
    logic [IDX_W-1:0]           w_seg;
    logic                       w_en;

    logic                       r_v1, r_v2, r_v3;
    logic [DATA_W-1:0]          r_x1, r_m1, r_c1;
    logic [IDX_W-1:0]           r_seg1, r_seg2, r_seg3;
    logic signed [2*DATA_W-1:0] r_p2;
    logic signed [DATA_W-1:0]   r_c2;
    logic [DATA_W-1:0]          r_out;

    logic signed [2*DATA_W-1:0] w_xe, w_me, w_prod, w_shift;
    logic [DATA_W-1:0]          w_res;
    logic                       w_unused;

    assign w_sel = cfg_sel_e'(cfg_sel);

    // Table writes land on the same edge that captures a sample, so that
    // sample still sees the old coefficients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SEG - 1; k++) r_bp[k] <= '0;
            for (int k = 0; k < SEG; k++) begin
                r_m[k] <= '0;
                r_c[k] <= '0;
            end
        end else if (cfg_we) begin
            for (int k = 0; k < SEG - 1; k++) begin
                if (w_sel == CFG_BP && cfg_addr == 4'(k)) r_bp[k] <= cfg_wdata;
            end
            for (int k = 0; k < SEG; k++) begin
                if (w_sel == CFG_M && cfg_addr == 4'(k)) r_m[k] <= cfg_wdata;
                if (w_sel == CFG_C && cfg_addr == 4'(k)) r_c[k] <= cfg_wdata;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SEG - 1; gi++) begin : g_bp
            assign w_bp[gi] = r_bp[gi];
        end
    endgenerate

    pwl_seg_index #(
        .SEG    (SEG),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_seg_index (
        .i_x   (in_data),
        .i_bp  (w_bp),
        .o_seg (w_seg)
    );

    // One advance enable for the whole pipe: a stalled output freezes every stage.
    assign w_en     = !r_v3 || out_ready;
    assign in_ready = w_en;

    assign w_xe    = {{DATA_W{r_x1[DATA_W-1]}}, r_x1};
    assign w_me    = {{DATA_W{r_m1[DATA_W-1]}}, r_m1};
    assign w_prod  = w_xe * w_me;
    assign w_shift = r_p2 >>> FRAC_W;

`ifdef PWL_SAT_EN
    logic signed [SAT_MAXW-1:0] w_red, w_sum, w_sat;
    assign w_red    = sat_trunc(SAT_MAXW'(w_shift), DATA_W + 1);
    assign w_sum    = w_red + SAT_MAXW'(r_c2);
    assign w_sat    = sat_trunc(w_sum, DATA_W);
    assign w_res    = w_sat[DATA_W-1:0];
    assign w_unused = ^w_sat[SAT_MAXW-1:DATA_W];
`else
    logic [DATA_W:0] w_sum;
    assign w_sum    = w_shift[DATA_W:0] + {r_c2[DATA_W-1], r_c2};
    assign w_res    = w_sum[DATA_W-1:0];
    assign w_unused = ^{w_shift[2*DATA_W-1:DATA_W+1], w_sum[DATA_W]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_x1   <= '0;
            r_m1   <= '0;
            r_c1   <= '0;
            r_seg1 <= '0;
            r_p2   <= '0;
            r_c2   <= '0;
            r_seg2 <= '0;
            r_out  <= '0;
            r_seg3 <= '0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (in_valid) begin
                r_x1   <= in_data;
                r_seg1 <= w_seg;
                r_m1   <= r_m[w_seg];
                r_c1   <= r_c[w_seg];
            end
            if (r_v1) begin
                r_p2   <= w_prod;
                r_c2   <= r_c1;
                r_seg2 <= r_seg1;
            end
            if (r_v2) begin
                r_out  <= w_res;
                r_seg3 <= r_seg2;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_data  = r_out;
    assign out_seg   = r_seg3;

endmodule
